// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode 7-segment scanner.
// Frame-coherent shadow of seg_data, blanking gap per slot.
module seg_scan_driver #(
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLANK_TICKS = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [19:0] seg_data,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int TW =
    (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST =
    TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_BLANK =
    TW'(BLANK_TICKS);

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [19:0]   shadow_data_q, shadow_data_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic [4:0]    code;

  // Character code to active-high gfedcba pattern.
  function automatic logic [6:0] decode(
    input logic [4:0] c
  );
    logic [6:0] s;
    unique case (c)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      5'd10:   s = 7'h77;
      5'd11:   s = 7'h39;
      5'd12:   s = 7'h5E;
      5'd13:   s = 7'h79;
      5'd14:   s = 7'h76;
      5'd15:   s = 7'h71;
      5'd16:   s = 7'h38;
      5'd17:   s = 7'h54;
      5'd18:   s = 7'h7C;
      5'd19:   s = 7'h73;
      5'd20:   s = 7'h3E;
      5'd21:   s = 7'h1E;
      5'd22:   s = 7'h6E;
      5'd23:   s = 7'h5C;
      5'd24:   s = 7'h50;
      5'd25:   s = 7'h78;
      5'd26:   s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Select the shadowed character of the current slot.
  always_comb begin
    unique case (idx_q)
      2'd0:    code = shadow_data_q[4:0];
      2'd1:    code = shadow_data_q[9:5];
      2'd2:    code = shadow_data_q[14:10];
      default: code = shadow_data_q[19:15];
    endcase
  end

  // Scan sequencing, shadow loads and next output values.
  always_comb begin
    idx_d         = idx_q;
    tick_d        = tick_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    frame_done_d  = 1'b0;
    an_d          = 4'hF;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    if (!enable) begin
      idx_d         = 2'd0;
      tick_d        = '0;
      shadow_data_d = seg_data;
      shadow_dp_d   = dp_mask;
    end else begin
      if (idx_q == 2'd0 && tick_q == '0) begin
        shadow_data_d = seg_data;
        shadow_dp_d   = dp_mask;
      end
      if (tick_q == TICK_LAST) begin
        tick_d       = '0;
        idx_d        = idx_q + 2'd1;
        frame_done_d = (idx_q == 2'd3);
      end else begin
        tick_d = tick_q + TW'(1);
      end
      if (phase_q == PH_ON) begin
        an_d[idx_q] = 1'b0;
        seg_d       = ~decode(code);
        dp_d        = ~shadow_dp_q[idx_q];
      end
    end
    phase_d = (tick_d < TICK_BLANK) ? PH_BLANK : PH_ON;
  end

  // State and registered outputs; reset darkens at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PH_BLANK;
      idx_q         <= 2'd0;
      tick_q        <= '0;
      shadow_data_q <= {5{5'd31}};
      shadow_dp_q   <= 4'h0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      tick_q        <= tick_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver.
// Expected outputs queued per cycle, popped at negedge.
module tb_seg_scan_driver;

  localparam int DT = 8;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [19:0] seg_data = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_scan_driver #(
    .DIGIT_TICKS(DT),
    .BLANK_TICKS(BT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .seg_data(seg_data),
    .dp_mask(dp_mask),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dpm;
    logic [19:0] nxt_data;
    logic [3:0]  nxt_dpm;
    int          chg;
  } row_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] dec(input logic [4:0] c);
    case (c)
      5'd0: return 7'h3F;  5'd1: return 7'h06;
      5'd2: return 7'h5B;  5'd3: return 7'h4F;
      5'd4: return 7'h66;  5'd5: return 7'h6D;
      5'd6: return 7'h7D;  5'd7: return 7'h07;
      5'd8: return 7'h7F;  5'd9: return 7'h6F;
      5'd10: return 7'h77; 5'd11: return 7'h39;
      5'd12: return 7'h5E; 5'd13: return 7'h79;
      5'd14: return 7'h76; 5'd15: return 7'h71;
      5'd16: return 7'h38; 5'd17: return 7'h54;
      5'd18: return 7'h7C; 5'd19: return 7'h73;
      5'd20: return 7'h3E; 5'd21: return 7'h1E;
      5'd22: return 7'h6E; 5'd23: return 7'h5C;
      5'd24: return 7'h50; 5'd25: return 7'h78;
      5'd26: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] segs_of(input logic [19:0] d);
    return {dec(d[19:15]), dec(d[14:10]),
            dec(d[9:5]), dec(d[4:0])};
  endfunction

  // Queue the first n cycles of a frame (k=0 is the boundary edge).
  task automatic push_frame(input logic [27:0] segs,
                            input logic [3:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int sl;
      int t;
      sl = k / DT;
      t  = k % DT;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      if (t >= BT) begin
        e.an[sl] = 1'b0;
        e.seg = ~segs[sl*7 +: 7];
        e.dp = ~m[sl];
      end
      e.fd = (k == 4*DT-1);
      q.push_back(e);
    end
  endtask

  task automatic push_dark(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      @(negedge clk);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard empty at %0t", $time);
      end else begin
        e = q.pop_front();
        if (an !== e.an || seg !== e.seg ||
            dp !== e.dp || frame_done !== e.fd) begin
          errors++;
          $display("FAIL scan t=%0t got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                   $time, an, seg, dp, frame_done,
                   e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  endtask

  task automatic frame_step(input logic [27:0] segs,
                            input logic [3:0] m,
                            input logic [19:0] nd,
                            input logic [3:0] nm,
                            input int chg);
    push_frame(segs, m, 4*DT);
    drain(chg);
    seg_data = nd;
    dp_mask  = nm;
    drain(4*DT - chg);
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got an=%b seg=%h dp=%b fd=%b want dark",
               name, an, seg, dp, frame_done);
    end
  endtask

  // Anti-ghosting monitor: one anode at most, gap between digits.
  int         dark_n = 0;
  logic [3:0] last_lit = 4'hF;
  always @(negedge clk) begin
    if (reset) begin
      dark_n = 0;
      last_lit = 4'hF;
    end else begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL ghost an=%b want <=1 low", an);
      end
      if (an == 4'hF) begin
        dark_n++;
      end else begin
        if (last_lit != 4'hF && last_lit != an) begin
          checks++;
          if (dark_n < BT) begin
            errors++;
            $display("FAIL gap got %0d want >=%0d", dark_n, BT);
          end
        end
        last_lit = an;
        dark_n = 0;
      end
    end
  end

  localparam logic [19:0] D_A = {5'd1, 5'd21, 5'd22, 5'd21};
  localparam logic [19:0] D_B = {5'd2, 5'd14, 5'd22, 5'd5};
  localparam logic [19:0] D_C = {5'd31, 5'd26, 5'd0, 5'd8};
  localparam logic [19:0] D_E = {5'd3, 5'd18, 5'd21, 5'd3};

  row_t        rows[3];
  logic [19:0] sh_d;
  logic [3:0]  sh_m;

  initial begin
    rows[0] = '{28'h0, 4'h0, D_B, 4'h0, 12};
    rows[0].segs = {7'h06, 7'h1E, 7'h6E, 7'h1E};
    rows[1] = '{28'h0, 4'h0, D_C, 4'b0101, 1};
    rows[1].segs = {7'h5B, 7'h76, 7'h6E, 7'h6D};
    rows[2] = '{28'h0, 4'b0101, D_C, 4'b0101, 1};
    rows[2].segs = {7'h00, 7'h40, 7'h3F, 7'h7F};

    seg_data = D_A;
    dp_mask  = 4'h0;
    enable   = 1'b1;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    check_dark("reset_state");
    reset = 1'b0;

    foreach (rows[i])
      frame_step(rows[i].segs, rows[i].dpm, rows[i].nxt_data,
                 rows[i].nxt_dpm, rows[i].chg);
    sh_d = D_C;
    sh_m = 4'b0101;

    for (int f = 0; f < 10; f++) begin
      logic [19:0] nd;
      logic [3:0]  nm;
      nd = 20'($urandom);
      nm = 4'($urandom);
      frame_step(segs_of(sh_d), sh_m, nd, nm,
                 1 + int'($urandom_range(30)));
      sh_d = nd;
      sh_m = nm;
    end

    push_frame(segs_of(sh_d), sh_m, 20);
    drain(20);
    enable   = 1'b0;
    seg_data = D_E;
    dp_mask  = 4'h0;
    push_dark(5);
    drain(5);
    enable = 1'b1;
    push_frame({7'h4F, 7'h7C, 7'h1E, 7'h4F}, 4'h0, 4*DT);
    drain(4*DT);

    push_frame(segs_of(D_E), 4'h0, 20);
    drain(20);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset_an got %b want 1011", an);
    end
    #2 reset = 1'b1;
    #1 check_dark("async_reset");
    @(negedge clk);
    reset = 1'b0;
    seg_data = D_A;
    push_frame({7'h06, 7'h1E, 7'h6E, 7'h1E}, 4'h0, 4*DT);
    drain(4*DT);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
